// File: rtl/control_juego.sv
// Tic-tac-toe game controller: board, turn, move count, win/draw evaluation.
// Latency: cell written on the edge that samples enter's rising edge, final state one edge later.
// Backpressure: none; move requests arriving in EVALUAR or a terminal state are dropped.
module control_juego #(
    parameter logic PRIMER_JUGADOR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enter,
    input  logic        reinicio,
    input  logic [2:0]  posX,
    input  logic [2:0]  posY,
    output logic [17:0] tablero,
    output logic        turno,
    output logic [2:0]  estado,
    output logic [3:0]  movimientos,
    output logic        jugadaInvalida,
    output logic [7:0]  lineaGanadora
);

    typedef enum logic [2:0] {
        JUGANDO = 3'b000,
        EVALUAR = 3'b001,
        GANA_X  = 3'b010,
        GANA_O  = 3'b011,
        EMPATE  = 3'b100
    } estado_t;

    estado_t     est;
    logic        enter_q;
    logic        pulso_enter;
    logic [3:0]  celda;
    logic        pos_ok;
    logic [15:0] libre;
    logic        jugada_ok;
    logic [1:0]  codigo;
    logic [8:0]  propia;
    logic [7:0]  lineas;

    assign estado = est;

    // Rising-edge detect on the level enter request, plus cell decode and legality
    always_comb begin
        pulso_enter = enter & ~enter_q;
        pos_ok      = (posX <= 3'd2) && (posY <= 3'd2);
        celda       = {1'b0, posY} * 4'd3 + {1'b0, posX};
        libre       = '0;
        for (int i = 0; i < 9; i++) begin
            libre[i] = (tablero[2*i +: 2] == 2'b00);
        end
        // Out-of-range cells index the zero-padded upper bits, so they read as occupied
        jugada_ok   = pos_ok && libre[celda];
    end

    // Winning-line mask for the player whose code matches the current turn
    always_comb begin
        codigo = turno ? 2'b10 : 2'b01;
        propia = '0;
        for (int i = 0; i < 9; i++) begin
            propia[i] = (tablero[2*i +: 2] == codigo);
        end
        lineas[0] = propia[0] & propia[1] & propia[2];
        lineas[1] = propia[3] & propia[4] & propia[5];
        lineas[2] = propia[6] & propia[7] & propia[8];
        lineas[3] = propia[0] & propia[3] & propia[6];
        lineas[4] = propia[1] & propia[4] & propia[7];
        lineas[5] = propia[2] & propia[5] & propia[8];
        lineas[6] = propia[0] & propia[4] & propia[8];
        lineas[7] = propia[2] & propia[4] & propia[6];
    end

    // Game FSM with all outputs registered; restart overrides every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            est            <= JUGANDO;
            tablero        <= '0;
            turno          <= PRIMER_JUGADOR;
            movimientos    <= '0;
            jugadaInvalida <= 1'b0;
            lineaGanadora  <= '0;
            enter_q        <= 1'b0;
        end else begin
            // enter_q tracks enter even during restart so a held level cannot replay as a move
            enter_q        <= enter;
            jugadaInvalida <= 1'b0;
            if (reinicio) begin
                est           <= JUGANDO;
                tablero       <= '0;
                turno         <= PRIMER_JUGADOR;
                movimientos   <= '0;
                lineaGanadora <= '0;
            end else begin
                case (est)
                    JUGANDO: begin
                        if (pulso_enter) begin
                            if (jugada_ok) begin
                                for (int i = 0; i < 9; i++) begin
                                    if (celda == 4'(i)) begin
                                        tablero[2*i +: 2] <= codigo;
                                    end
                                end
                                if (movimientos != 4'd9) begin
                                    movimientos <= movimientos + 4'd1;
                                end
                                est <= EVALUAR;
                            end else begin
                                jugadaInvalida <= 1'b1;
                            end
                        end
                    end
                    EVALUAR: begin
                        lineaGanadora <= lineas;
                        // A completed line wins even on the ninth move; turno keeps the winner
                        if (lineas != 8'd0) begin
                            est <= turno ? GANA_O : GANA_X;
                        end else if (movimientos == 4'd9) begin
                            est <= EMPATE;
                        end else begin
                            turno <= ~turno;
                            est   <= JUGANDO;
                        end
                    end
                    default: begin
                        // Terminal states hold the board until restart
                        est <= est;
                    end
                endcase
            end
        end
    end

endmodule
